// File: rtl/atm_session_ctrl_pkg.sv
// rtl/atm_session_ctrl_pkg.sv - shared types and default constants for the ATM session controller
package atm_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PIN   = 2'd1,
    S_MENU  = 2'd2,
    S_EJECT = 2'd3
  } state_t;

  localparam logic [1:0] OP_BAL  = 2'b00;
  localparam logic [1:0] OP_DEP  = 2'b01;
  localparam logic [1:0] OP_WDR  = 2'b10;
  localparam logic [1:0] OP_EXIT = 2'b11;

  localparam int DEF_NUM_CARDS     = 8;
  localparam int DEF_CARD_W        = 3;
  localparam int DEF_PSW_W         = 4;
  localparam int DEF_BAL_W         = 20;
  localparam int DEF_INIT_BAL      = 1000;
  localparam int DEF_MAX_TRIES     = 3;
  localparam int DEF_TIMEOUT_CYC   = 1000;
  localparam int DEF_SESSION_LIMIT = 500;

endpackage

// File: rtl/atm_session_ctrl_if.sv
// rtl/atm_session_ctrl_if.sv - front-panel / display bundle between panel decoder and session controller
interface atm_session_ctrl_if
  import atm_pkg::*;
#(
  parameter int CARD_W = DEF_CARD_W,
  parameter int PSW_W  = DEF_PSW_W,
  parameter int BAL_W  = DEF_BAL_W
);
  logic              card_in;
  logic [CARD_W-1:0] card_number;
  logic              pin_valid;
  logic [PSW_W-1:0]  password_input;
  logic              op_valid;
  logic [1:0]        operation;
  logic [BAL_W-1:0]  value;
  logic [BAL_W-1:0]  updated_balance;
  logic              op_done;
  logic              error;
  logic              wrong_psw;
  logic              card_out;
  logic              card_locked;

  modport master (
    output card_in, card_number, pin_valid, password_input, op_valid, operation, value,
    input  updated_balance, op_done, error, wrong_psw, card_out, card_locked
  );

  modport slave (
    input  card_in, card_number, pin_valid, password_input, op_valid, operation, value,
    output updated_balance, op_done, error, wrong_psw, card_out, card_locked
  );
endinterface

// File: rtl/atm_session_ctrl_timeout.sv
// rtl/atm_session_ctrl_timeout.sv - restartable inactivity counter with one-cycle timeout pulse
module atm_timeout #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_restart,
  input  logic i_enable,
  output logic o_timeout
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_clear;

  // a restart in the firing cycle wins, so the pulse is suppressed
  assign w_clear   = i_start | i_restart;
  assign o_timeout = i_enable & ~w_clear & (r_cnt == LAST);

  // count idle cycles while enabled; saturate at the last value until cleared
  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/atm_session_ctrl.sv
// rtl/atm_session_ctrl.sv - multi-card ATM session FSM with lockout, timeout, optional cap (ATM_SESSION_LIMIT_EN)
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter int NUM_CARDS     = DEF_NUM_CARDS,
  parameter int CARD_W        = DEF_CARD_W,
  parameter int PSW_W         = DEF_PSW_W,
  parameter int BAL_W         = DEF_BAL_W,
  parameter int INIT_BAL      = DEF_INIT_BAL,
  parameter int MAX_TRIES     = DEF_MAX_TRIES,
  parameter int TIMEOUT_CYC   = DEF_TIMEOUT_CYC,
  parameter int SESSION_LIMIT = DEF_SESSION_LIMIT
) (
  input logic               clk,
  input logic               rst,
  atm_session_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_CARDS);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  state_t           r_state, w_nxt_state;
  logic [BAL_W-1:0] r_bal [NUM_CARDS];
  logic             r_lock [NUM_CARDS];
  logic [IDX_W-1:0] r_idx;
  logic [TRY_W-1:0] r_tries, w_tries;
  logic [BAL_W-1:0] r_upd_bal, w_upd_bal;
  logic             r_op_done, r_error, r_wrong_psw, r_card_out, r_card_locked;
  logic             w_op_done, w_error, w_wrong_psw, w_card_out, w_card_locked;
  logic             w_accept, w_input_ok, w_bal_we, w_lock_set, w_to_start, w_timeout;
  logic [BAL_W-1:0] w_bal_wdata, w_cur_bal;
  logic [BAL_W:0]   w_sum;
  logic [IDX_W-1:0] w_in_idx;
  logic             w_card_ok, w_in_locked, w_sess_over;

  // PIN of card i is i mod 2^PSW_W, so it is derived from the index rather than stored
  assign w_in_idx    = bus.card_number[IDX_W-1:0];
  assign w_card_ok   = int'(bus.card_number) < NUM_CARDS;
  assign w_in_locked = r_lock[w_in_idx];
  assign w_cur_bal   = r_bal[r_idx];
  assign w_sum       = {1'b0, w_cur_bal} + {1'b0, bus.value};

`ifdef ATM_SESSION_LIMIT_EN
  logic [BAL_W-1:0] r_sess;
  logic [BAL_W:0]   w_sess_sum;
  logic             w_wdr_ok;
  assign w_sess_sum  = {1'b0, r_sess} + {1'b0, bus.value};
  assign w_sess_over = w_sess_sum > (BAL_W + 1)'(SESSION_LIMIT);

  // running total of successful withdrawals, cleared when a card is accepted
  always_ff @(posedge clk) begin
    if (rst || w_accept) r_sess <= '0;
    else if (w_wdr_ok)   r_sess <= w_sess_sum[BAL_W-1:0];
  end
`else
  assign w_sess_over = 1'b0;
`endif

  atm_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_to_start),
    .i_restart (w_input_ok),
    .i_enable  ((r_state == S_PIN) || (r_state == S_MENU)),
    .o_timeout (w_timeout)
  );

  assign w_to_start = (w_nxt_state != r_state) &&
                      ((w_nxt_state == S_PIN) || (w_nxt_state == S_MENU));

  // session state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt_state;
  end

  // next-state, response pulses and table write requests
  always_comb begin
    w_nxt_state   = r_state;
    w_op_done     = 1'b0;
    w_error       = 1'b0;
    w_wrong_psw   = 1'b0;
    w_card_out    = 1'b0;
    w_card_locked = r_card_locked;
    w_upd_bal     = r_upd_bal;
    w_tries       = r_tries;
    w_accept      = 1'b0;
    w_input_ok    = 1'b0;
    w_bal_we      = 1'b0;
    w_bal_wdata   = w_cur_bal;
    w_lock_set    = 1'b0;
`ifdef ATM_SESSION_LIMIT_EN
    w_wdr_ok      = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: if (bus.card_in) begin
        if (!w_card_ok || w_in_locked) begin
          w_error       = 1'b1;
          w_card_out    = 1'b1;
          w_card_locked = w_card_ok && w_in_locked;
        end else begin
          w_accept      = 1'b1;
          w_card_locked = 1'b0;
          w_tries       = '0;
          w_nxt_state   = S_PIN;
        end
      end
      S_PIN: if (bus.pin_valid) begin
        w_input_ok = 1'b1;
        if (bus.password_input == PSW_W'(r_idx)) begin
          w_nxt_state = S_MENU;
          w_upd_bal   = w_cur_bal;
        end else begin
          w_wrong_psw = 1'b1;
          w_tries     = r_tries + TRY_W'(1);
          if (r_tries == TRY_W'(MAX_TRIES - 1)) begin
            w_lock_set    = 1'b1;
            w_error       = 1'b1;
            w_card_locked = 1'b1;
            w_nxt_state   = S_EJECT;
          end
        end
      end else if (w_timeout) begin
        w_nxt_state = S_EJECT;
      end
      S_MENU: if (bus.op_valid) begin
        w_input_ok = 1'b1;
        unique case (bus.operation)
          OP_BAL: begin
            w_op_done = 1'b1;
            w_upd_bal = w_cur_bal;
          end
          OP_DEP: begin
            if (w_sum[BAL_W]) begin
              w_error = 1'b1;
            end else begin
              w_bal_we    = 1'b1;
              w_bal_wdata = w_sum[BAL_W-1:0];
              w_upd_bal   = w_sum[BAL_W-1:0];
              w_op_done   = 1'b1;
            end
          end
          OP_WDR: begin
            if ((bus.value > w_cur_bal) || w_sess_over) begin
              w_error = 1'b1;
            end else begin
              w_bal_we    = 1'b1;
              w_bal_wdata = w_cur_bal - bus.value;
              w_upd_bal   = w_cur_bal - bus.value;
              w_op_done   = 1'b1;
`ifdef ATM_SESSION_LIMIT_EN
              w_wdr_ok    = 1'b1;
`endif
            end
          end
          OP_EXIT: w_nxt_state = S_EJECT;
        endcase
      end else if (w_timeout) begin
        w_nxt_state = S_EJECT;
      end
      S_EJECT: begin
        w_card_out  = 1'b1;
        w_nxt_state = S_IDLE;
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // account table, active-card bookkeeping and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CARDS; i++) begin
        r_bal[i]  <= BAL_W'(INIT_BAL);
        r_lock[i] <= 1'b0;
      end
      r_idx         <= '0;
      r_tries       <= '0;
      r_upd_bal     <= '0;
      r_op_done     <= 1'b0;
      r_error       <= 1'b0;
      r_wrong_psw   <= 1'b0;
      r_card_out    <= 1'b0;
      r_card_locked <= 1'b0;
    end else begin
      if (w_accept)   r_idx         <= w_in_idx;
      if (w_bal_we)   r_bal[r_idx]  <= w_bal_wdata;
      if (w_lock_set) r_lock[r_idx] <= 1'b1;
      r_tries       <= w_tries;
      r_upd_bal     <= w_upd_bal;
      r_op_done     <= w_op_done;
      r_error       <= w_error;
      r_wrong_psw   <= w_wrong_psw;
      r_card_out    <= w_card_out;
      r_card_locked <= w_card_locked;
    end
  end

  assign bus.updated_balance = r_upd_bal;
  assign bus.op_done         = r_op_done;
  assign bus.error           = r_error;
  assign bus.wrong_psw       = r_wrong_psw;
  assign bus.card_out        = r_card_out;
  assign bus.card_locked     = r_card_locked;
endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb/tb_atm_session_ctrl.sv - scoreboard bench for atm_session_ctrl
module tb_atm_session_ctrl;
  import atm_pkg::*;

  localparam int T = DEF_TIMEOUT_CYC;

  typedef struct {
    bit od, err, wp, co, lk;
    int bal;
    int at;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  atm_session_ctrl_if #(.CARD_W(4), .PSW_W(DEF_PSW_W), .BAL_W(DEF_BAL_W)) bus ();

  atm_session_ctrl #(.CARD_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(bit od, bit err, bit wp, bit co, bit lk, int bal, int at);
    sb.push_back('{od, err, wp, co, lk, bal, at});
  endfunction

  // monitor: flag overdue expectations, then match every response pulse
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].at < cyc) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL missing@%0d: no response seen, want od=%b err=%b wp=%b co=%b", e.at, e.od, e.err, e.wp, e.co);
    end
    if (!rst && (bus.op_done || bus.error || bus.wrong_psw || bus.card_out)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected@%0d: od=%b err=%b wp=%b co=%b", cyc, bus.op_done, bus.error, bus.wrong_psw, bus.card_out);
      end else begin
        e = sb.pop_front();
        if (bus.op_done != e.od || bus.error != e.err || bus.wrong_psw != e.wp || bus.card_out != e.co ||
            bus.card_locked != e.lk || int'(bus.updated_balance) != e.bal || cyc != e.at) begin
          errors++;
          $display("FAIL resp@%0d: got od=%b err=%b wp=%b co=%b lk=%b bal=%0d, want od=%b err=%b wp=%b co=%b lk=%b bal=%0d @%0d",
                   cyc, bus.op_done, bus.error, bus.wrong_psw, bus.card_out, bus.card_locked, bus.updated_balance,
                   e.od, e.err, e.wp, e.co, e.lk, e.bal, e.at);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic card(input int n, input bit rej, input bit lk, input int bal);
    int c;
    bus.card_in = 1'b1; bus.card_number = 4'(n); c = cyc;
    if (rej) push(0, 1, 0, 1, lk, bal, c + 1);
    @(negedge clk); bus.card_in = 1'b0;
  endtask

  // kind: 0 match, 1 wrong, 2 wrong and final
  task automatic pin(input int p, input int kind, input int bal, output int c);
    bus.pin_valid = 1'b1; bus.password_input = 4'(p); c = cyc;
    if (kind == 1) push(0, 0, 1, 0, 0, bal, c + 1);
    if (kind == 2) begin
      push(0, 1, 1, 0, 1, bal, c + 1);
      push(0, 0, 0, 1, 1, bal, c + 2);
    end
    @(negedge clk); bus.pin_valid = 1'b0;
  endtask

  task automatic op(input logic [1:0] o, input int v, input bit ok, input int bal, input bit both, output int c);
    bus.op_valid = 1'b1; bus.operation = o; bus.value = 20'(v);
    bus.pin_valid = both; bus.password_input = '0; c = cyc;
    if (o == OP_EXIT) push(0, 0, 0, 1, 0, bal, c + 2);
    else              push(ok, !ok, 0, 0, 0, bal, c + 1);
    @(negedge clk); bus.op_valid = 1'b0; bus.pin_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, c2, n;
    bus.card_in = 0; bus.card_number = '0; bus.pin_valid = 0; bus.password_input = '0;
    bus.op_valid = 0; bus.operation = '0; bus.value = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.op_done || bus.error || bus.wrong_psw || bus.card_out || bus.card_locked || bus.updated_balance != 0) begin
      errors++;
      $display("FAIL reset: got od=%b err=%b wp=%b co=%b lk=%b bal=%0d, want all 0",
               bus.op_done, bus.error, bus.wrong_psw, bus.card_out, bus.card_locked, bus.updated_balance);
    end
    rst = 1'b0;
    @(negedge clk);

    // card 2: withdraw, query (with stray pin_valid), exit
    card(2, 0, 0, 0);
    pin(2, 0, 0, c);
    op(OP_WDR, 300, 1, 700, 0, c);
    op(OP_BAL, 0, 1, 700, 1, c);
    op(OP_EXIT, 0, 0, 700, 0, c);
    idle(3);

    // card 3: three wrong PINs lock it, then it is rejected
    card(3, 0, 0, 700);
    pin(0, 1, 700, c);
    pin(0, 1, 700, c);
    pin(0, 2, 700, c);
    idle(3);
    card(3, 1, 1, 700);
    idle(1);

    // invalid card 9 rejected; controller still in IDLE afterwards
    card(9, 1, 0, 700);
    card(1, 0, 0, 700);
    pin(1, 0, 700, c);
    op(OP_BAL, 0, 1, 1000, 0, c);
    op(OP_EXIT, 0, 0, 1000, 0, c);
    idle(3);

    // card 4: overflow, overdraw, exact-boundary ops
    card(4, 0, 0, 1000);
    pin(4, 0, 1000, c);
    op(OP_DEP, 1048576 - 1000, 0, 1000, 0, c);
    op(OP_WDR, 1001, 0, 1000, 0, c);
    op(OP_WDR, 1000, 1, 0, 0, c);
    op(OP_DEP, 0, 1, 0, 0, c);
    op(OP_WDR, 0, 1, 0, 0, c);
    op(OP_DEP, 1048575, 1, 1048575, 0, c);
    op(OP_DEP, 1, 0, 1048575, 0, c);
    op(OP_EXIT, 0, 0, 1048575, 0, c);
    idle(3);

    // card 5: idle in MENU until the timeout ejects it without error
    card(5, 0, 0, 1048575);
    pin(5, 0, 1048575, c);
    push(0, 0, 0, 1, 0, 1000, c + T + 2);
    while (cyc < c + T + 4) @(negedge clk);

    // card 6: an op on the final idle cycle wins over the timeout
    card(6, 0, 0, 1000);
    pin(6, 0, 1000, c);
    while (cyc < c + T) @(negedge clk);
    op(OP_BAL, 0, 1, 1000, 0, c2);
    op(OP_EXIT, 0, 0, 1000, 0, c2);
    idle(3);

    // card 7: second withdraw depends on the session cap
    card(7, 0, 0, 1000);
    pin(7, 0, 1000, c);
    op(OP_WDR, 300, 1, 700, 0, c);
`ifdef ATM_SESSION_LIMIT_EN
    op(OP_WDR, 250, 0, 700, 0, c);
    op(OP_EXIT, 0, 0, 700, 0, c);
`else
    op(OP_WDR, 250, 1, 450, 0, c);
    op(OP_EXIT, 0, 0, 450, 0, c);
`endif

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    idle(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses still pending, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
